// File: rtl/prog_sequencer.sv
// Program sequencer: Start/Ack run control, PC generation with call/return stack,
// stall handling, HALT detection and saturating cycle/instruction counters.
module prog_sequencer #(
  parameter int PC_W       = 10,
  parameter int INST_W     = 9,
  parameter int CNT_W      = 16,
  parameter int RET_DEPTH  = 4,
  parameter int START_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic [INST_W-1:0] Instruction,
  input  logic              BranchAbs,
  input  logic              BranchRelEn,
  input  logic              BranchCond,
  input  logic              Call,
  input  logic              Ret,
  input  logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Ack,
  output logic              Running,
  output logic [CNT_W-1:0]  CycleCt,
  output logic [CNT_W-1:0]  InstCt,
  output logic              StackErr
);

  localparam int IDX_W = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_ack;
  logic              r_running;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_inst;
  logic [SP_W-1:0]   r_sp;
  logic              r_err;
  logic [PC_W-1:0]   r_stack [RET_DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Relative target: Target is a two's-complement offset; the sum wraps mod 2^PC_W.
  function automatic logic [PC_W-1:0] rel_add(input logic [PC_W-1:0] pc,
                                              input logic [PC_W-1:0] off);
    logic signed [PC_W-1:0] s_pc;
    logic signed [PC_W-1:0] s_off;
    s_pc  = signed'(pc);
    s_off = signed'(off);
    return unsigned'(s_pc + s_off);
  endfunction

  logic              w_halt;
  logic              w_empty;
  logic              w_full;
  logic              w_step;
  logic              w_push;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_rel;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_top_idx;

  assign w_halt     = &Instruction;
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SP_W'(RET_DEPTH));
  assign w_step     = (r_state == S_RUN) && !Stall && !w_halt;
  assign w_push     = Reset && w_step && !Ret && Call && !w_full;
  assign w_pc_inc   = r_pc + 1'b1;
  assign w_pc_rel   = rel_add(r_pc, Target);
  assign w_push_idx = r_sp[IDX_W-1:0];
  assign w_top_idx  = r_sp[IDX_W-1:0] - 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ack     <= 1'b0;
      r_running <= 1'b0;
      r_cyc     <= '0;
      r_inst    <= '0;
      r_sp      <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state   <= S_RUN;
            r_pc      <= PC_W'(START_ADDR);
            r_ack     <= 1'b0;
            r_running <= 1'b1;
            r_cyc     <= '0;
            r_inst    <= '0;
            r_sp      <= '0;
            r_err     <= 1'b0;
          end
        end
        S_RUN: begin
          r_cyc <= sat_inc(r_cyc);
          // Stalled cycles count time but make no control decision at all.
          if (!Stall) begin
            if (w_halt) begin
              r_state   <= S_DONE;
              r_ack     <= 1'b1;
              r_running <= 1'b0;
            end else if (Ret) begin
              if (w_empty) begin
                r_err     <= 1'b1;
                r_state   <= S_DONE;
                r_ack     <= 1'b1;
                r_running <= 1'b0;
              end else begin
                r_pc   <= r_stack[w_top_idx];
                r_sp   <= r_sp - 1'b1;
                r_inst <= sat_inc(r_inst);
              end
            end else if (Call) begin
              if (w_full) begin
                r_err     <= 1'b1;
                r_state   <= S_DONE;
                r_ack     <= 1'b1;
                r_running <= 1'b0;
              end else begin
                r_pc   <= Target;
                r_sp   <= r_sp + 1'b1;
                r_inst <= sat_inc(r_inst);
              end
            end else if (BranchAbs) begin
              r_pc   <= Target;
              r_inst <= sat_inc(r_inst);
            end else if (BranchRelEn && BranchCond) begin
              r_pc   <= w_pc_rel;
              r_inst <= sat_inc(r_inst);
            end else begin
              r_pc   <= w_pc_inc;
              r_inst <= sat_inc(r_inst);
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ack     <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Return-address storage is plain data: written on push only, never reset.
  always_ff @(posedge Clk) begin
    if (w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign ProgCtr  = r_pc;
  assign Ack      = r_ack;
  assign Running  = r_running;
  assign CycleCt  = r_cyc;
  assign InstCt   = r_inst;
  assign StackErr = r_err;

endmodule

// File: tb/tb_prog_sequencer.sv
// Testbench for prog_sequencer: directed scenarios plus randomized control traffic,
// every cycle compared against a behavioural model built on a queue-based stack.
module tb_prog_sequencer;

  localparam int PC_W       = 10;
  localparam int INST_W     = 9;
  localparam int CNT_W      = 16;
  localparam int RET_DEPTH  = 4;
  localparam int START_ADDR = 0;
  localparam int unsigned PC_MOD  = 1 << PC_W;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned HALT    = (1 << INST_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset, Start, Stall, BranchAbs, BranchRelEn, BranchCond, Call, Ret;
  logic [INST_W-1:0] Instruction;
  logic [PC_W-1:0]   Target;
  logic [PC_W-1:0]   ProgCtr;
  logic              Ack, Running, StackErr;
  logic [CNT_W-1:0]  CycleCt, InstCt;

  logic [INST_W-1:0] rom [PC_MOD];

  always #5 Clk = ~Clk;
  assign Instruction = rom[ProgCtr];

  prog_sequencer #(
    .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W),
    .RET_DEPTH(RET_DEPTH), .START_ADDR(START_ADDR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .Instruction(Instruction), .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn),
    .BranchCond(BranchCond), .Call(Call), .Ret(Ret), .Target(Target),
    .ProgCtr(ProgCtr), .Ack(Ack), .Running(Running), .CycleCt(CycleCt),
    .InstCt(InstCt), .StackErr(StackErr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state: 0 idle, 1 run, 2 done.
  int          m_state;
  int unsigned m_pc, m_cyc, m_inst;
  bit          m_err;
  int unsigned m_stk[$];

  function automatic int unsigned cnt_up(input int unsigned v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic model_step();
    int unsigned ins;
    int          off;
    if (!Reset) begin
      m_state = 0; m_pc = 0; m_cyc = 0; m_inst = 0; m_err = 0; m_stk.delete();
    end else if (m_state != 1) begin
      if (Start) begin
        m_state = 1; m_pc = START_ADDR; m_cyc = 0; m_inst = 0; m_err = 0; m_stk.delete();
      end
    end else begin
      m_cyc = cnt_up(m_cyc);
      if (!Stall) begin
        ins = rom[m_pc];
        if (ins == HALT) begin
          m_state = 2;
        end else if (Ret) begin
          if (m_stk.size() == 0) begin m_err = 1; m_state = 2; end
          else begin m_pc = m_stk.pop_back(); m_inst = cnt_up(m_inst); end
        end else if (Call) begin
          if (m_stk.size() == RET_DEPTH) begin m_err = 1; m_state = 2; end
          else begin
            m_stk.push_back((m_pc + 1) % PC_MOD);
            m_pc = Target; m_inst = cnt_up(m_inst);
          end
        end else if (BranchAbs) begin
          m_pc = Target; m_inst = cnt_up(m_inst);
        end else if (BranchRelEn && BranchCond) begin
          off  = (Target >= PC_MOD / 2) ? int'(Target) - int'(PC_MOD) : int'(Target);
          m_pc = int'((int'(m_pc) + off + int'(PC_MOD)) % int'(PC_MOD));
          m_inst = cnt_up(m_inst);
        end else begin
          m_pc = (m_pc + 1) % PC_MOD; m_inst = cnt_up(m_inst);
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pc", ProgCtr, m_pc);
    check_eq("ack", Ack, (m_state == 2) ? 1 : 0);
    check_eq("running", Running, (m_state == 1) ? 1 : 0);
    check_eq("cycle_ct", CycleCt, m_cyc);
    check_eq("inst_ct", InstCt, m_inst);
    check_eq("stack_err", StackErr, m_err);
  endtask

  task automatic step();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic clear_ctl();
    Start = 0; Stall = 0; BranchAbs = 0; BranchRelEn = 0; BranchCond = 0;
    Call = 0; Ret = 0; Target = '0;
  endtask

  task automatic do_call(input logic [PC_W-1:0] t);
    clear_ctl(); Call = 1; Target = t; step(); clear_ctl();
  endtask

  task automatic restart();
    clear_ctl(); Start = 1; step(); clear_ctl();
  endtask

  int unsigned c0, i0;

  initial begin
    for (int a = 0; a < int'(PC_MOD); a++) rom[a] = '0;
    rom[5] = INST_W'(HALT);
    clear_ctl();
    Reset = 0;
    m_state = 0; m_pc = 0; m_cyc = 0; m_inst = 0; m_err = 0;
    @(negedge Clk);

    // Reset and a straight-line run to HALT at address 5.
    step(); step();
    check_eq("reset_pc", ProgCtr, 0);
    check_eq("reset_ack", Ack, 0);
    Reset = 1;
    restart();
    for (int i = 0; i < 20 && !Ack; i++) step();
    check_eq("halt_ack", Ack, 1);
    check_eq("halt_pc", ProgCtr, 5);
    check_eq("halt_inst", InstCt, 5);
    check_eq("halt_cyc", CycleCt, 6);
    check_eq("halt_running", Running, 0);

    // Restart from DONE, then relative branches and PC wrap.
    restart();
    check_eq("restart_ack", Ack, 0);
    check_eq("restart_pc", ProgCtr, START_ADDR);
    step(); step(); step();
    BranchRelEn = 1; BranchCond = 1; Target = 10'h3FE; step(); clear_ctl();
    check_eq("rel_back", ProgCtr, 1);
    step(); step();
    BranchRelEn = 1; BranchCond = 0; Target = 10'h3FE; step(); clear_ctl();
    check_eq("rel_not_taken", ProgCtr, 4);
    BranchAbs = 1; Target = 10'h3FF; step(); clear_ctl();
    step();
    check_eq("pc_wrap", ProgCtr, 0);

    // Nested calls to full depth and matching returns.
    do_call(10'h100); do_call(10'h200); do_call(10'h300); do_call(10'h040);
    check_eq("call_depth_pc", ProgCtr, 10'h040);
    Ret = 1; step(); check_eq("ret1", ProgCtr, 10'h301);
    step(); check_eq("ret2", ProgCtr, 10'h201);
    step(); check_eq("ret3", ProgCtr, 10'h101);
    step(); check_eq("ret4", ProgCtr, 10'h001);
    clear_ctl();
    check_eq("ret_err", StackErr, 0);

    // Overflow on a fifth call, then underflow after a fresh start.
    do_call(10'h100); do_call(10'h200); do_call(10'h300); do_call(10'h040);
    do_call(10'h080);
    check_eq("ovf_err", StackErr, 1);
    check_eq("ovf_ack", Ack, 1);
    check_eq("ovf_pc", ProgCtr, 10'h040);
    step(); step();
    restart();
    Ret = 1; step(); clear_ctl();
    check_eq("unf_err", StackErr, 1);
    check_eq("unf_ack", Ack, 1);

    // Stall holds a pending HALT.
    rom[2] = INST_W'(HALT);
    restart(); step(); step();
    c0 = CycleCt; i0 = InstCt;
    Stall = 1; step(); step(); step(); Stall = 0;
    check_eq("stall_pc", ProgCtr, 2);
    check_eq("stall_ack", Ack, 0);
    check_eq("stall_cyc", CycleCt, c0 + 3);
    check_eq("stall_inst", InstCt, i0);
    step();
    check_eq("stall_release_ack", Ack, 1);
    rom[2] = '0;

    // Reset in the middle of a run.
    rom[5] = '0;
    restart();
    for (int i = 0; i < 7; i++) step();
    check_eq("midrun_pc", ProgCtr, 7);
    Reset = 0; step(); Reset = 1;
    check_eq("midrun_rst_pc", ProgCtr, 0);
    check_eq("midrun_rst_cyc", CycleCt, 0);
    check_eq("midrun_rst_run", Running, 0);

    // Randomized traffic over a random program.
    for (int a = 0; a < int'(PC_MOD); a++)
      rom[a] = ($urandom_range(0, 99) < 3) ? INST_W'(HALT) : INST_W'($urandom_range(0, HALT - 1));
    for (int n = 0; n < 4000; n++) begin
      Reset       = ($urandom_range(0, 299) != 0);
      Start       = ($urandom_range(0, 7) == 0);
      Stall       = ($urandom_range(0, 4) == 0);
      Ret         = ($urandom_range(0, 9) == 0);
      Call        = ($urandom_range(0, 8) == 0);
      BranchAbs   = ($urandom_range(0, 9) == 0);
      BranchRelEn = ($urandom_range(0, 4) == 0);
      BranchCond  = ($urandom_range(0, 1) == 0);
      Target      = PC_W'($urandom_range(0, PC_MOD - 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
